control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Microstate sequencer for the control unit. It holds the current control state and
//  walks FETCH -> DECODE -> EXECUTE -> FETCH. At DECODE it jumps to the start state
//  supplied by the instruction state encoder (State_Sel). It stalls on memory states
//  until MOC, with a watchdog. It drives the Moore control strobes and counts retired
//  instructions. Sits between the state encoder and the datapath/memory interface.
// PARAMETERS
//  MOC_TIMEOUT  16  max cycles waited for moc in a memory state before bus fault (>=2)
//  COUNT_W      32  width of retired-instruction counter
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        async active-low reset
//  state_sel    in   7        encoder start state (0=unknown, 5=ADDU, 6=SB, 10=BEQ)
//  moc          in   1        memory operation complete, level, sampled on clk
//  cond         in   1        ALU equal flag for BEQ, sampled in state 10 only
//  state        out  7        current microstate
//  mem_req      out  1        memory access active (states 2, 8)
//  mem_we       out  1        write access (state 8 only)
//  ir_ld        out  1        load IR from MDR (state 3)
//  pc_inc       out  1        PC<-PC+4 (state 2, cycle moc seen)
//  instr_done   out  1        1-cycle pulse on any retirement into FETCH0
//  illegal      out  1        1-cycle pulse: DECODE saw state_sel not in {5,6,10}
//  bus_err      out  1        1-cycle pulse: moc watchdog expired
//  instr_count  out  COUNT_W  retired instructions, wraps at 2^COUNT_W
// BEHAVIOUR
//  Reset (async, rst_n=0): state=0, watchdog=0, instr_count=0, all pulses 0. Holds while low.
//  State transitions (one per clk edge):
//   0  IDLE    -> 1 (first edge after rst_n rises)
//   1  FETCH0  MAR<-PC -> 2
//   2  FETCH1  mem read; moc ? 3 : hold; watchdog expiry -> 1 + bus_err
//   3  FETCH2  ir_ld -> 4
//   4  DECODE  state_sel in {5,6,10} -> state_sel; else -> 1 + illegal
//   5  ADDU    rd<-rs+rt -> 1
//   6  SB0     MAR<-rs+imm -> 7
//   7  SB1     MDR<-rt -> 8
//   8  SB2     mem write; moc ? 1 : hold; watchdog expiry -> 1 + bus_err
//   10 BEQ0    cond ? 11 : 1
//   11 BEQ1    PC<-PC+offset -> 1
//   any other encoding -> 1 + illegal (defensive)
//  Strobes are combinational from state only (Moore). pc_inc=1 only in state 2 with moc=1.
//  Watchdog: zeroed on entry to 2 or 8. It increments each cycle held with moc=0. In the
//   cycle it equals MOC_TIMEOUT-1 with moc=0, exit to 1 with bus_err; no retirement.
//   Exit is always to 1, including from state 2 (fetch is abandoned).
//  moc and expiry in the same cycle: moc wins, normal transition, no bus_err.
//  moc is ignored outside states 2/8. state_sel is ignored outside state 4.
//  Retirement: transitions 5->1, 8->1 (on moc), 10->1, 11->1. These set instr_done for one
//   cycle (registered, aligned with state=1) and add 1 to instr_count (mod 2^COUNT_W).
//   illegal and bus_err exits do not retire.
//  Pulses are registered: asserted in the cycle state first shows 1 after the event.
//  Latency: ADDU 5 clk FETCH0->FETCH0 with moc=1 at first sample. SB 7, BEQ taken 6, not-taken 5.
//  Reset mid-instruction: immediate return to 0. The counter clears. No pulses are emitted.
// TESTING
//  T1 reset, moc=1, state_sel=5 -> states 0,1,2,3,4,5,1; instr_done once; count=1
//  T2 state_sel=6, moc low 3 cycles in state 8 -> holds 8 for 4 clk; mem_we=1 throughout; then 1
//  T3 state_sel=10: cond=1 -> 10,11,1; cond=0 -> 10,1; both increment count
//  T4 state_sel=0 at DECODE -> 4->1, illegal pulse; count unchanged
//  T5 moc=0 forever in state 2 -> leaves after 16 clk, bus_err pulse; moc=1 on 16th -> state 3, no bus_err
//  T6 rst_n low while in state 7, mid-clock -> state=0 immediately; count=0; COUNT_W=4 wraps 15->0

Source files
------------

// File: rtl/control_sequencer.sv
// Microstate sequencer: FETCH -> DECODE -> EXECUTE -> FETCH, with MOC stalls, a MOC watchdog and Moore strobes.
// Status pulses and the retired-instruction counter are registered and line up with the return to FETCH0.
module control_sequencer #(
  parameter int MOC_TIMEOUT = 16,
  parameter int COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         state_sel,
  input  logic               moc,
  input  logic               cond,
  output logic [6:0]         state,
  output logic               mem_req,
  output logic               mem_we,
  output logic               ir_ld,
  output logic               pc_inc,
  output logic               instr_done,
  output logic               illegal,
  output logic               bus_err,
  output logic [COUNT_W-1:0] instr_count
);

  localparam int WD_W = (MOC_TIMEOUT > 2) ? $clog2(MOC_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MOC_TIMEOUT - 1);

  typedef enum logic [6:0] {
    S_IDLE   = 7'd0,
    S_FETCH0 = 7'd1,
    S_FETCH1 = 7'd2,
    S_FETCH2 = 7'd3,
    S_DECODE = 7'd4,
    S_ADDU   = 7'd5,
    S_SB0    = 7'd6,
    S_SB1    = 7'd7,
    S_SB2    = 7'd8,
    S_BEQ0   = 7'd10,
    S_BEQ1   = 7'd11
  } state_e;

  state_e             state_q, state_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [COUNT_W-1:0] count_q;
  logic               done_q, illegal_q, bus_err_q;
  logic               retire_d, illegal_d, bus_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wd_q      <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      count_q   <= count_q + {{(COUNT_W-1){1'b0}}, retire_d};
      done_q    <= retire_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    retire_d  = 1'b0;
    illegal_d = 1'b0;
    bus_err_d = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH0;
      S_FETCH0: begin
        state_d = S_FETCH1;
        wd_d    = '0;
      end
      S_FETCH1: begin
        // moc has priority over a watchdog expiry in the same cycle
        if (moc) begin
          state_d = S_FETCH2;
        end else if (wd_q == WD_LAST) begin
          state_d   = S_FETCH0;
          bus_err_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_FETCH2: state_d = S_DECODE;
      S_DECODE: begin
        if (state_sel == S_ADDU || state_sel == S_SB0 || state_sel == S_BEQ0) begin
          state_d = state_e'(state_sel);
        end else begin
          state_d   = S_FETCH0;
          illegal_d = 1'b1;
        end
      end
      S_ADDU: begin
        state_d  = S_FETCH0;
        retire_d = 1'b1;
      end
      S_SB0:    state_d = S_SB1;
      S_SB1: begin
        state_d = S_SB2;
        wd_d    = '0;
      end
      S_SB2: begin
        if (moc) begin
          state_d  = S_FETCH0;
          retire_d = 1'b1;
        end else if (wd_q == WD_LAST) begin
          state_d   = S_FETCH0;
          bus_err_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_BEQ0: begin
        if (cond) begin
          state_d = S_BEQ1;
        end else begin
          state_d  = S_FETCH0;
          retire_d = 1'b1;
        end
      end
      S_BEQ1: begin
        state_d  = S_FETCH0;
        retire_d = 1'b1;
      end
      default: begin
        state_d   = S_FETCH0;
        illegal_d = 1'b1;
      end
    endcase
  end

  assign state       = state_q;
  assign mem_req     = (state_q == S_FETCH1) || (state_q == S_SB2);
  assign mem_we      = (state_q == S_SB2);
  assign ir_ld       = (state_q == S_FETCH2);
  assign pc_inc      = (state_q == S_FETCH1) && moc;
  assign instr_done  = done_q;
  assign illegal     = illegal_q;
  assign bus_err     = bus_err_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: an instruction-level reference model checked every cycle,
// plus literal state/pulse/count expectations per scenario. A 4-bit-counter copy shares the stimulus.
module tb_control_sequencer;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  state_sel;
  logic        moc, cond;

  logic [6:0]  state, state4;
  logic        mem_req, mem_we, ir_ld, pc_inc, instr_done, illegal, bus_err;
  logic        mem_req4, mem_we4, ir_ld4, pc_inc4, instr_done4, illegal4, bus_err4;
  logic [31:0] instr_count;
  logic [3:0]  instr_count4;

  int checks = 0;
  int errors = 0;

  control_sequencer #(.MOC_TIMEOUT(TO), .COUNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .state_sel(state_sel), .moc(moc), .cond(cond),
    .state(state), .mem_req(mem_req), .mem_we(mem_we), .ir_ld(ir_ld), .pc_inc(pc_inc),
    .instr_done(instr_done), .illegal(illegal), .bus_err(bus_err), .instr_count(instr_count));

  control_sequencer #(.MOC_TIMEOUT(TO), .COUNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .state_sel(state_sel), .moc(moc), .cond(cond),
    .state(state4), .mem_req(mem_req4), .mem_we(mem_we4), .ir_ld(ir_ld4), .pc_inc(pc_inc4),
    .instr_done(instr_done4), .illegal(illegal4), .bus_err(bus_err4), .instr_count(instr_count4));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks the microstate, how long it has waited on memory, and retirements.
  logic [6:0]  m_state;
  int          m_wait;
  logic [31:0] m_count;
  logic        m_done, m_ill, m_berr;

  always @(posedge clk or negedge rst_n) begin
    logic [6:0] prev, nxt;
    logic       berr, ill;
    if (!rst_n) begin
      m_state <= 7'd0; m_wait <= 0; m_count <= '0;
      m_done <= 1'b0; m_ill <= 1'b0; m_berr <= 1'b0;
    end else begin
      prev = m_state;
      berr = 1'b0;
      ill  = 1'b0;
      nxt  = 7'd1;
      if (prev == 7'd2 || prev == 7'd8) begin
        if (moc)                   nxt = (prev == 7'd2) ? 7'd3 : 7'd1;
        else if (m_wait + 1 >= TO) berr = 1'b1;
        else                       nxt = prev;
      end else if (prev == 7'd4) begin
        if (state_sel inside {7'd5, 7'd6, 7'd10}) nxt = state_sel;
        else ill = 1'b1;
      end else if (prev == 7'd10) begin
        nxt = cond ? 7'd11 : 7'd1;
      end else if (prev inside {7'd1, 7'd2, 7'd3, 7'd6, 7'd7}) begin
        nxt = prev + 7'd1;
      end
      m_wait  <= (nxt == prev) ? m_wait + 1 : 0;
      m_done  <= (nxt == 7'd1) && (prev inside {7'd5, 7'd8, 7'd10, 7'd11}) && !berr;
      m_count <= m_count + (((nxt == 7'd1) && (prev inside {7'd5, 7'd8, 7'd10, 7'd11}) && !berr) ? 1 : 0);
      m_ill   <= ill;
      m_berr  <= berr;
      m_state <= nxt;
    end
  end

  always @(negedge clk) begin
    chk("state", state, m_state);
    chk("mem_req", mem_req, (m_state == 7'd2) || (m_state == 7'd8));
    chk("mem_we", mem_we, m_state == 7'd8);
    chk("ir_ld", ir_ld, m_state == 7'd3);
    chk("pc_inc", pc_inc, (m_state == 7'd2) && moc);
    chk("instr_done", instr_done, m_done);
    chk("illegal", illegal, m_ill);
    chk("bus_err", bus_err, m_berr);
    chk("instr_count", instr_count, m_count);
    chk("state4", state4, m_state);
    chk("instr_count4", instr_count4, m_count[3:0]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string nm, input logic [6:0] exp);
    step();
    chk(nm, state, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; state_sel = 7'd0; moc = 1'b0; cond = 1'b0;
    step(); step();
    chk("rst_state", state, 7'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_pulses", {instr_done, illegal, bus_err}, 3'b000);
    rst_n = 1'b1;

    // T1: ADDU with immediate moc
    moc = 1'b1; state_sel = 7'd5;
    st("t1_s1", 7'd1);
    st("t1_s2", 7'd2);
    chk("t1_pc_inc", pc_inc, 1'b1);
    st("t1_s3", 7'd3);
    chk("t1_ir_ld", ir_ld, 1'b1);
    st("t1_s4", 7'd4);
    st("t1_s5", 7'd5);
    st("t1_s1b", 7'd1);
    chk("t1_done", instr_done, 1'b1);
    chk("t1_count", instr_count, 32'd1);

    // T2: SB with memory write stalled three cycles
    state_sel = 7'd6;
    st("t2_s2", 7'd2); st("t2_s3", 7'd3); st("t2_s4", 7'd4);
    st("t2_s6", 7'd6); st("t2_s7", 7'd7);
    moc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st("t2_hold8", 7'd8);
      chk("t2_mem_we", mem_we, 1'b1);
    end
    moc = 1'b1;
    st("t2_s1", 7'd1);
    chk("t2_done", instr_done, 1'b1);
    chk("t2_count", instr_count, 32'd2);

    // T3: BEQ taken then not taken
    state_sel = 7'd10; cond = 1'b1;
    st("t3a_s2", 7'd2); st("t3a_s3", 7'd3); st("t3a_s4", 7'd4);
    st("t3a_s10", 7'd10); st("t3a_s11", 7'd11); st("t3a_s1", 7'd1);
    chk("t3a_count", instr_count, 32'd3);
    cond = 1'b0;
    st("t3b_s2", 7'd2); st("t3b_s3", 7'd3); st("t3b_s4", 7'd4);
    st("t3b_s10", 7'd10); st("t3b_s1", 7'd1);
    chk("t3b_done", instr_done, 1'b1);
    chk("t3b_count", instr_count, 32'd4);

    // T4: unknown opcode at DECODE
    state_sel = 7'd0;
    st("t4_s2", 7'd2); st("t4_s3", 7'd3); st("t4_s4", 7'd4); st("t4_s1", 7'd1);
    chk("t4_illegal", illegal, 1'b1);
    chk("t4_done", instr_done, 1'b0);
    chk("t4_count", instr_count, 32'd4);

    // T5: fetch watchdog expiry, then moc arriving on the last allowed cycle
    moc = 1'b0; state_sel = 7'd5;
    for (int i = 0; i < TO; i++) st("t5a_hold2", 7'd2);
    st("t5a_s1", 7'd1);
    chk("t5a_bus_err", bus_err, 1'b1);
    chk("t5a_count", instr_count, 32'd4);
    for (int i = 0; i < TO; i++) st("t5b_hold2", 7'd2);
    moc = 1'b1;
    st("t5b_s3", 7'd3);
    chk("t5b_bus_err", bus_err, 1'b0);
    st("t5b_s4", 7'd4); st("t5b_s5", 7'd5); st("t5b_s1", 7'd1);
    chk("t5b_count", instr_count, 32'd5);

    // T6: asynchronous reset while in SB1, then 4-bit counter wrap
    state_sel = 7'd6;
    st("t6_s2", 7'd2); st("t6_s3", 7'd3); st("t6_s4", 7'd4);
    st("t6_s6", 7'd6); st("t6_s7", 7'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_state", state, 7'd0);
    chk("t6_rst_count", instr_count, 32'd0);
    chk("t6_rst_pulses", {instr_done, illegal, bus_err}, 3'b000);
    step();
    chk("t6_rst_hold", state, 7'd0);
    rst_n = 1'b1;
    state_sel = 7'd5;
    st("t6_s1", 7'd1);
    for (int n = 1; n <= 16; n++) begin
      repeat (5) step();
      chk("t6_loop_s1", state, 7'd1);
      if (n == 15) chk("t6_cnt4_15", instr_count4, 4'd15);
    end
    chk("t6_cnt4_wrap", instr_count4, 4'd0);
    chk("t6_cnt32", instr_count, 32'd16);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
